// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter granting C cores single-beat access to one shared memory.
// Latency: req seen in IDLE -> strobe next cycle -> done the cycle after; back-to-back grants every 2 cycles.
// Backpressure: cores hold req until their done pulse; losers wait, at most C-1 transactions.
module mem_rr_arbiter #(
    parameter int C  = 8,
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [C-1:0]         i_req,
    input  logic [C-1:0]         i_we,
    input  logic [AW-1:0]        i_adr  [C],
    input  logic [DW-1:0]        i_wdat [C],
    output logic [C-1:0]         o_gnt,
    output logic [C-1:0]         o_done,
    output logic [DW-1:0]        o_rdat,
    output logic [AW-1:0]        o_mem_adr,
    output logic [DW-1:0]        o_mem_wdat,
    output logic                 o_mem_we,
    output logic                 o_mem_re,
    input  logic [DW-1:0]        i_mem_rdat
);

    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_wdat;
    logic [DW-1:0]   r_rdat;

    logic [C-1:0]    w_owner_oh;
    logic [C-1:0]    w_req_eff;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_latch;

    assign w_owner_oh = {{(C-1){1'b0}}, 1'b1} << r_owner;

    // Scan from the highest offset down so the requester closest to r_ptr is the last (winning) assignment.
    // In RESP the finishing owner is masked so a sticky requester cannot win twice in a row.
    always_comb begin
        w_req_eff = i_req;
        if (r_state == S_RESP) begin
            w_req_eff = i_req & ~w_owner_oh;
        end
        w_found = 1'b0;
        w_win   = '0;
        for (int i = C - 1; i >= 0; i--) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= C) begin
                j = j - C;
            end
            if (w_req_eff[j]) begin
                w_found = 1'b1;
                w_win   = IW'(j);
            end
        end
    end

    assign w_ptr_nxt = (w_win == IW'(C - 1)) ? '0 : w_win + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_found) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_owner <= w_win;
                r_ptr   <= w_ptr_nxt;
                r_we    <= i_we[w_win];
                r_adr   <= i_adr[w_win];
                r_wdat  <= i_wdat[w_win];
            end
            if (r_state == S_ACCESS && !r_we) begin
                r_rdat <= i_mem_rdat;
            end
        end
    end

    // Outputs decode straight from state so an async reset drops them without a clock edge.
    always_comb begin
        o_gnt    = '0;
        o_done   = '0;
        o_mem_we = 1'b0;
        o_mem_re = 1'b0;
        case (r_state)
            S_ACCESS: begin
                o_gnt    = w_owner_oh;
                o_mem_we = r_we;
                o_mem_re = !r_we;
            end
            S_RESP: begin
                o_gnt  = w_owner_oh;
                o_done = w_owner_oh;
            end
            default: begin
                o_gnt = '0;
            end
        endcase
    end

    assign o_mem_adr  = r_adr;
    assign o_mem_wdat = r_wdat;
    assign o_rdat     = r_rdat;

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter C, default 8: number of requesting cores, C >= 2.
REQ-002 Parameter AW, default 16: memory address width.
REQ-003 Parameter DW, default 16: memory data width.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 reset  input  1: asynchronous, active-low reset; it takes effect immediately on assertion (reset=0), independent of clk.
REQ-006 req  input  C: per-core access request; level, held by core until its done pulse.
REQ-007 we  input  C: per-core write flag (1=write, 0=read); sampled with adr/wdat at grant.
REQ-008 adr  input  C x AW (unpacked array): per-core address.
REQ-009 wdat  input  C x DW (unpacked array): per-core write data.
REQ-010 gnt  output  C: one-hot current owner; all-zero when no owner.
REQ-011 done  output  C: one-hot, one-cycle completion pulse to the owner.
REQ-012 rdat  output  DW: registered read data; valid while done is nonzero for a read.
REQ-013 mem_adr  output  AW: address to shared memory.
REQ-014 mem_wdat  output  DW: write data to shared memory.
REQ-015 mem_we  output  1: memory write strobe.
REQ-016 mem_re  output  1: memory read strobe.
REQ-017 mem_rdat  input  DW: combinational read data from memory.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; state, owner index, latched we/adr/wdat, round-robin pointer ptr and rdat are the only registers.
REQ-019 Arbitration: the winner is the first requester with req=1, searching indices ptr, ptr+1, ... C-1, 0, ... ptr-1 with wrap-around modulo C.
REQ-020 IDLE: if any req=1, latch winner index, we, adr, wdat; set ptr = (winner+1) mod C; go to ACCESS; else stay in IDLE.
REQ-021 ACCESS: mem_we = latched we and mem_re = !latched we, both for exactly this cycle; mem_adr/mem_wdat = latched values; capture mem_rdat into rdat at the end of the cycle on reads; next state is RESP.
REQ-022 RESP: done = onehot(owner) for exactly this cycle; arbitrate with the current owner's req masked; if a winner exists, latch it as in REQ-020 and go directly to ACCESS; else go to IDLE.
REQ-023 gnt = onehot(owner) in ACCESS and RESP; gnt = 0 in IDLE.
REQ-024 mem_we = mem_re = 0 outside ACCESS; mem_adr/mem_wdat hold the last latched values outside ACCESS.
REQ-025 Latency: req seen in IDLE at edge k -> gnt and mem strobe in cycle k+1 -> done in cycle k+2.
REQ-026 Throughput: under continuous contention, one transaction per 2 cycles, no IDLE cycle between transactions.
REQ-027 Fairness: a requester holding req waits at most C-1 transactions (2*(C-1)+2 cycles) before its grant.
REQ-028 Changes to req/we/adr/wdat after grant do not affect the in-flight transaction; deassertion of the owner's req after grant does not abort it.
REQ-029 An owner that keeps req=1 after its done is treated as a new request, subject to the round-robin pointer.
REQ-030 rdat is unchanged by write transactions.

Reset
REQ-031 On reset=0: state=IDLE, ptr=0, owner=0, rdat=0, latched we/adr/wdat=0; gnt=0, done=0, mem_we=0, mem_re=0 immediately, including mid-ACCESS; the in-flight transaction is dropped with no done.
REQ-032 First arbitration after reset release starts the search at index 0.

Verification
REQ-033 Write: only req[3]=1, we[3]=1, adr[3]=0x0010, wdat[3]=0xBEEF -> next cycle gnt=0x08, mem_we=1, mem_adr=0x0010, mem_wdat=0xBEEF; following cycle done=0x08; then gnt=0.
REQ-034 Read: only req[5]=1, we[5]=0, adr[5]=0x0200, mem_rdat=0x1234 in ACCESS -> mem_re=1 for one cycle; done=0x20 and rdat=0x1234 in the next cycle.
REQ-035 Full contention: all 8 req=1 from reset -> grant order 0,1,2,...,7,0, each owner held 2 cycles, no idle gap, done pulses 2 cycles apart.
REQ-036 Wrap: ptr=3 (after a grant to 2), req[7] and req[1] both 1 -> 7 granted first, then 1.
REQ-037 Sticky owner: req[0] and req[4] held high continuously -> grants alternate 0,4,0,4; core 0 is never granted twice in a row.
REQ-038 Reset mid-op: reset=0 during ACCESS of a write by core 6 -> mem_we and gnt drop without waiting for clk, no done pulse; after release with req[6] and req[2] set -> core 2 granted first.
